// File: rtl/dram_piso_ctrl.sv
`default_nettype none
// =====================================================================
// dram_piso_ctrl : valid/ready word intake and load/shift sequencing
//                  for the DRAM serializer PISO, LSB first.
// Macro SER_PARITY_EN adds a trailing even-parity slot.   Rev 1.0
// =====================================================================
module dram_piso_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             piso_load,
  output logic             piso_shift,
  output logic [WIDTH-1:0] piso_data,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             busy,
  output logic             par_bit,
  output logic             par_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit STREAM = (GAP == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  state_t           after_word;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             last_bit;
  logic             last_serial;
  logic             accept;

  assign last_bit   = (state_q == ST_SHIFT) && (idx_q == IDX_LAST);
  assign after_word = STREAM ? ST_IDLE : ST_GAP;

`ifdef SER_PARITY_EN
  assign last_serial = (state_q == ST_PAR);
`else
  assign last_serial = last_bit;
`endif

  // Ready is decoded from state only; abort blocks any accept that cycle.
  assign in_ready   = !abort && ((state_q == ST_IDLE) || (STREAM && last_serial));
  assign accept     = in_valid && in_ready;
  assign piso_load  = accept;
  assign piso_data  = in_data;
  assign piso_shift = !abort && (state_q == ST_SHIFT) && (idx_q != IDX_LAST);
  assign bit_valid  = (state_q == ST_SHIFT);
  assign bit_last   = last_bit;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
`ifdef SER_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = after_word;
`endif
          end
        end
        ST_PAR:  state_d = after_word;
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
      // A streaming accept on the final serial cycle restarts with no bubble.
      if (accept) begin
        state_d = ST_SHIFT;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

`ifdef SER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = ^in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_valid = (state_q == ST_PAR);
  assign par_bit   = par_valid && par_q;
`else
  assign par_valid = 1'b0;
  assign par_bit   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_piso_ctrl.sv
`default_nettype none
// =====================================================================
// tb_dram_piso_ctrl : scoreboard bench, one GAP=2 and one GAP=0 instance,
//                     each feeding a behavioural PISO.          Rev 1.0
// =====================================================================
module tb_dram_piso_ctrl;

  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    int   cyc;
    logic b;
    logic last;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic             vld   [2];
  logic             abt   [2];
  logic [WIDTH-1:0] din   [2];
  logic             rdy   [2];
  logic             load  [2];
  logic             shift [2];
  logic [WIDTH-1:0] pdata [2];
  logic [WIDTH-1:0] piso  [2];
  logic             bv    [2];
  logic             bl    [2];
  logic             busy  [2];
  logic             pbit  [2];
  logic             pvld  [2];

  sb_t bq [2][$];
  sb_t pq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_piso_ctrl #(.WIDTH(WIDTH), .GAP(2)) u_dut_g2 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(din[0]), .in_ready(rdy[0]),
    .abort(abt[0]), .piso_load(load[0]), .piso_shift(shift[0]), .piso_data(pdata[0]),
    .bit_valid(bv[0]), .bit_last(bl[0]), .busy(busy[0]), .par_bit(pbit[0]),
    .par_valid(pvld[0])
  );

  dram_piso_ctrl #(.WIDTH(WIDTH), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(din[1]), .in_ready(rdy[1]),
    .abort(abt[1]), .piso_load(load[1]), .piso_shift(shift[1]), .piso_data(pdata[1]),
    .bit_valid(bv[1]), .bit_last(bl[1]), .busy(busy[1]), .par_bit(pbit[1]),
    .par_valid(pvld[1])
  );

  // Behavioural PISO: shift wins over load, serial output is bit 0.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (shift[i])     piso[i] <= piso[i] >> 1;
      else if (load[i]) piso[i] <= pdata[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  task automatic push_word(input int i, input logic [WIDTH-1:0] w, input int t);
    sb_t e;
    for (int k = 0; k < WIDTH; k++) begin
      e.cyc = t + 1 + k; e.b = w[k]; e.last = (k == WIDTH - 1);
      bq[i].push_back(e);
    end
    if (PB == 1) begin
      e.cyc = t + WIDTH + 1; e.b = ^w; e.last = 1'b0;
      pq[i].push_back(e);
    end
  endtask

  task automatic push_bit(input int i, input int t, input logic b);
    sb_t e;
    e.cyc = t; e.b = b; e.last = 1'b0;
    bq[i].push_back(e);
  endtask

  task automatic mon(input int i);
    sb_t e;
    if (bv[i]) begin
      if (bq[i].size() == 0) begin
        check($sformatf("u%0d_bit_extra", i), bv[i], 0);
      end else begin
        e = bq[i].pop_front();
        check($sformatf("u%0d_bit_cyc", i), cyc, e.cyc);
        check($sformatf("u%0d_bit_val", i), piso[i][0], e.b);
        check($sformatf("u%0d_bit_last", i), bl[i], e.last);
      end
    end else begin
      if (bl[i]) check($sformatf("u%0d_last_no_valid", i), bl[i], 0);
      if (bq[i].size() > 0 && bq[i][0].cyc <= cyc) begin
        check($sformatf("u%0d_bit_missing", i), bv[i], 1);
        void'(bq[i].pop_front());
      end
    end
    if (pvld[i]) begin
      if (pq[i].size() == 0) begin
        check($sformatf("u%0d_par_extra", i), pvld[i], 0);
      end else begin
        e = pq[i].pop_front();
        check($sformatf("u%0d_par_cyc", i), cyc, e.cyc);
        check($sformatf("u%0d_par_bit", i), pbit[i], e.b);
        check($sformatf("u%0d_par_no_bv", i), bv[i], 0);
      end
    end else if (pq[i].size() > 0 && pq[i][0].cyc <= cyc) begin
      check($sformatf("u%0d_par_missing", i), pvld[i], 1);
      void'(pq[i].pop_front());
    end
    if (load[i] && shift[i]) check($sformatf("u%0d_load_shift", i), shift[i], 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic b_pair(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1);
    int t;
    nxt();
    t = cyc;
    vld[1] = 1'b1; din[1] = w0;
    push_word(1, w0, t);
    push_word(1, w1, t + WIDTH + PB);
    smp();
    check("t2_acc0", rdy[1], 1);
    for (int c = 1; c <= WIDTH + PB; c++) begin
      nxt(); din[1] = w1; smp();
      check("t2_ready", rdy[1], (c == WIDTH + PB));
    end
    nxt(); vld[1] = 1'b0;
    for (int c = 0; c < 2 * WIDTH + 4; c++) begin smp(); nxt(); end
    smp();
    check("t2_busy_end", busy[1], 0);
    check("t2_sb_empty", bq[1].size() + pq[1].size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin vld[i] = 1'b0; abt[i] = 1'b0; din[i] = '0; end
    repeat (3) nxt();
    smp();
    check("rst_outs", {busy[0], busy[1], bv[0], bv[1], load[0], load[1],
                       shift[0], shift[1], pvld[0], pvld[1]}, 0);
    nxt(); rst = 1'b0;

    // Idle after reset: ready held, no strobes.
    for (int c = 0; c < 20; c++) begin
      smp();
      check("idle", {rdy[0], rdy[1], busy[0], busy[1], load[0], load[1],
                     shift[0], shift[1], bv[0], bv[1]}, 10'b11_0000_0000);
      nxt();
    end

    // GAP=2, single word 0xA5.
    t = cyc;
    vld[0] = 1'b1; din[0] = 8'hA5;
    push_word(0, 8'hA5, t);
    smp();
    check("t1_accept", {rdy[0], load[0]}, 2'b11);
    for (int c = 1; c <= 11 + PB; c++) begin
      nxt();
      if (c == 1) vld[0] = 1'b0;
      smp();
      check("t1_shift", shift[0], (c <= 7));
      check("t1_ready", rdy[0], (c == 11 + PB));
      check("t1_busy", busy[0], (c <= 10 + PB));
    end

    // GAP=0 back-to-back streaming.
    b_pair(8'h01, 8'h80);
    b_pair(8'hA5, 8'h07);

    // Abort mid-word, with a competing offer in the abort cycle.
    nxt();
    t = cyc;
    vld[0] = 1'b1; din[0] = 8'hFF;
    for (int k = 0; k < 4; k++) push_bit(0, t + 1 + k, 1'b1);
    nxt(); vld[0] = 1'b0;
    nxt(); nxt(); nxt();
    abt[0] = 1'b1; vld[0] = 1'b1; din[0] = 8'hAA;
    smp();
    check("t3_abort_ready", rdy[0], 0);
    check("t3_abort_strobes", {shift[0], load[0]}, 2'b00);
    nxt();
    abt[0] = 1'b0; din[0] = 8'h0F;
    push_word(0, 8'h0F, cyc);
    smp();
    check("t3_post_abort", {busy[0], bv[0], rdy[0], load[0]}, 4'b0011);
    nxt(); vld[0] = 1'b0;
    for (int c = 0; c < 16; c++) begin smp(); nxt(); end
    smp();
    check("t3_sb_empty", bq[0].size() + pq[0].size(), 0);
    check("t3_idle", busy[0], 0);

    // Reset pulse mid-word.
    nxt();
    t = cyc;
    vld[0] = 1'b1; din[0] = 8'h3C;
    push_bit(0, t + 1, 1'b0);
    push_bit(0, t + 2, 1'b0);
    nxt(); vld[0] = 1'b0;
    nxt(); nxt();
    rst = 1'b1;
    smp();
    check("t4_rst_outs", {busy[0], bv[0], bl[0], shift[0], load[0], pvld[0]}, 0);
    nxt(); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      smp();
      check("t4_after_rst", {rdy[0], bv[0], busy[0]}, 3'b100);
      nxt();
    end
    vld[0] = 1'b1; din[0] = 8'h5A;
    push_word(0, 8'h5A, cyc);
    nxt(); vld[0] = 1'b0;
    for (int c = 0; c < 16; c++) begin smp(); nxt(); end
    smp();
    check("final_sb_empty", bq[0].size() + pq[0].size() + bq[1].size() + pq[1].size(), 0);
    check("final_idle", {busy[0], busy[1], rdy[0], rdy[1]}, 4'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_piso_ctrl.md
Name: dram_piso_ctrl

Overview:
Sequencer for the DRAM serializer PISO. Accepts parallel words over a valid/ready handshake and drives the PISO load and shift strobes so the word leaves LSB-first, one bit per clock. Flags which PISO output cycles carry valid bits and inserts a programmable idle gap between words. Sits between the command/data path and the PISO instance.

Parameters:
WIDTH, 8, word width; must match the PISO instance; WIDTH >= 2.
GAP, 1, idle cycles inserted after each word; 0 allows back-to-back streaming.
CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  parallel word offered.
in_data  input  WIDTH  word to serialize.
in_ready  output  1  controller can accept a word this cycle.
abort  input  1  synchronous cancel of the current word.
piso_load  output  1  PISO load strobe.
piso_shift  output  1  PISO shift strobe.
piso_data  output  WIDTH  PISO parallel input; combinational copy of in_data.
bit_valid  output  1  PISO serial output carries a valid data bit this cycle.
bit_last  output  1  current valid bit is the word MSB.
busy  output  1  state != IDLE.
par_bit  output  1  even-parity bit; see Optional Feature.
par_valid  output  1  par_bit valid this cycle.

Behaviour:
- States: IDLE, SHIFT, PAR (only with the feature), GAP.
- Reset: state=IDLE, bit index=0, gap counter=0. Registered outputs 0. in_ready=1 once rst deasserts.
- in_ready decodes registered state only; it has no combinational path from in_valid. It is 1 when:
  - state is IDLE, or
  - GAP=0 and this is the final serial cycle of a word (SHIFT with idx=WIDTH-1 and no parity, or PAR).
  - abort=1 forces in_ready=0.
- Accept = in_valid & in_ready. piso_load = accept (combinational). piso_data = in_data.
- Accept at cycle T: bit k appears on the PISO output at T+1+k (k=0..WIDTH-1). bit_valid=1 on those cycles and bit_last=1 at T+WIDTH.
- SHIFT state: piso_shift=1 while idx<WIDTH-1. Never assert piso_shift on the last bit. piso_load and piso_shift are never high in the same cycle, because the PISO gives shift priority.
- After the last bit (or after PAR): go to GAP for exactly GAP cycles if GAP>0, otherwise go to IDLE.
- GAP=0 with accept on the final cycle: go to SHIFT with idx=0, giving continuous bit_valid with no bubble.
- abort:
  - Any state: next state is IDLE, idx and gap counter clear, no strobes that cycle.
  - PISO contents are left as-is; bit_valid drops the next cycle.
  - abort takes priority over accept.
- rst mid-word: immediate return to reset values; any partial word is discarded.
- in_valid while in_ready=0: ignored. The upstream holds the word.

Optional Feature:
Macro SER_PARITY_EN.
- Defined:
  - The even parity of in_data is captured at accept.
  - After the last data bit, the controller spends one PAR cycle with par_valid=1, par_bit = XOR of the word, bit_valid=0, and no piso_shift.
  - Then GAP or IDLE follows as above.
- Undefined: no PAR state; par_bit and par_valid are tied to 0. The ports always exist.

Test Plan:
- WIDTH=8, GAP=2, send 0xA5 at T -> bit_valid T+1..T+8 with serial 1,0,1,0,0,1,0,1; bit_last at T+8; piso_shift high T+1..T+7 only; in_ready low T+1..T+10 and high at T+11.
- GAP=0, send 0x01 then 0x80 with in_valid held -> second accept at T+8; 16 consecutive bit_valid cycles; serial is 1 then fourteen 0s then 1; no cycle with piso_load=piso_shift=1.
- abort at T+4 during 0xFF -> busy=0 and bit_valid=0 from T+5; in_ready=1 at T+5; the next word 0x0F serializes correctly.
- rst pulse at T+3 mid-word -> all outputs 0 immediately; after release in_ready=1 and no stale bit_valid.
- SER_PARITY_EN, GAP=0: 0xA5 -> par_valid=1, par_bit=0 at T+9. 0x07 -> par_bit=1. A word accepted during PAR starts bits at PAR+1.
- in_valid=0 for 20 cycles after reset -> state IDLE, no strobes, in_ready stays 1.
